// File: rtl/llc_bus_responder.sv
`timescale 1ns/1ps
// llc_bus_responder
// Shared-bus responder behind the LLC bus-operation interface. It accepts one
// bus operation at a time, broadcasts it as a snoop to the peer caches,
// combines their results, waits for a peer writeback on HITM, models memory
// latency, and returns the combined snoop result with a one-cycle pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   LLC request handshake (ready only while idle)
//   req_op, req_addr      bus op (1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM), address
//   snp_valid/op/addr     snoop broadcast to peers (op/addr are the latched request)
//   snp_ack, snp_result   per-peer ack strobe and 2-bit result (00 HIT, 01 HITM, 10 NOHIT)
//   wb_valid              HITM peer writeback complete
//   rsp_valid, rsp_snoop  one-cycle response pulse and combined snoop result
//   timeout_err           one-cycle pulse after a snoop or writeback timeout
module llc_bus_responder #(
  parameter int ADDR_BITS     = 32,
  parameter int PEERS         = 3,
  parameter int SNOOP_TIMEOUT = 15,
  parameter int MEM_LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 snp_valid,
  output logic [2:0]           snp_op,
  output logic [ADDR_BITS-1:0] snp_addr,
  input  logic [PEERS-1:0]     snp_ack,
  input  logic [2*PEERS-1:0]   snp_result,
  input  logic                 wb_valid,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_snoop,
  output logic                 timeout_err
);

  localparam int MAX_LIMIT = (SNOOP_TIMEOUT > MEM_LATENCY) ? SNOOP_TIMEOUT : MEM_LATENCY;
  localparam int CW        = $clog2(MAX_LIMIT + 1);
  localparam logic [CW-1:0] SNP_LAST = CW'(SNOOP_TIMEOUT - 1);
  localparam logic [CW-1:0] MEM_LAST = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] RES_HIT   = 2'b00;
  localparam logic [1:0] RES_HITM  = 2'b01;
  localparam logic [1:0] RES_NOHIT = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNOOP   = 3'd1,
    WB_WAIT = 3'd2,
    MEM     = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [PEERS-1:0] mask_r;
  logic             hitm_r;
  logic             hit_r;
  logic [CW-1:0]    cnt_r;

  logic [PEERS-1:0] new_ack_s;
  logic [PEERS-1:0] mask_nxt_s;
  logic             hitm_nxt_s;
  logic             hit_nxt_s;
  logic             all_acked_s;
  logic             snp_last_s;
  logic [1:0]       code_s;

  // Any HITM dominates, then any HIT, otherwise NOHIT.
  function automatic logic [1:0] combine(input logic hitm, input logic hit);
    if (hitm) begin
      return RES_HITM;
    end else if (hit) begin
      return RES_HIT;
    end else begin
      return RES_NOHIT;
    end
  endfunction

  // Snoop accumulation for this cycle: only first-time acks contribute, and
  // code 11 falls through as NOHIT because it sets neither flag.
  always_comb begin
    new_ack_s  = snp_ack & ~mask_r;
    mask_nxt_s = mask_r | snp_ack;
    hitm_nxt_s = hitm_r;
    hit_nxt_s  = hit_r;
    code_s     = 2'b00;
    for (int i = 0; i < PEERS; i++) begin
      code_s     = snp_result[2*i +: 2];
      hitm_nxt_s = hitm_nxt_s | (new_ack_s[i] & (code_s == RES_HITM));
      hit_nxt_s  = hit_nxt_s  | (new_ack_s[i] & (code_s == RES_HIT));
    end
    all_acked_s = &mask_nxt_s;
    snp_last_s  = (cnt_r == SNP_LAST);
  end

  // Main FSM with registered outputs; the counter is shared between
  // SNOOP, WB_WAIT and MEM and cleared on entry to each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      mask_r      <= '0;
      hitm_r      <= 1'b0;
      hit_r       <= 1'b0;
      cnt_r       <= '0;
      req_ready   <= 1'b1;
      snp_valid   <= 1'b0;
      snp_op      <= 3'd0;
      snp_addr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_snoop   <= RES_NOHIT;
      timeout_err <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r      <= req_op;
            snp_op    <= req_op;
            snp_addr  <= req_addr;
            mask_r    <= '0;
            cnt_r     <= '0;
            hitm_r    <= 1'b0;
            hit_r     <= 1'b0;
            req_ready <= 1'b0;
            case (req_op)
              OP_READ, OP_INV, OP_RWIM: begin
                state_r   <= SNOOP;
                snp_valid <= 1'b1;
              end
              OP_WRITE: begin
                state_r <= MEM;
              end
              default: begin
                state_r   <= RESP;
                rsp_valid <= 1'b1;
                rsp_snoop <= RES_NOHIT;
              end
            endcase
          end
        end
        SNOOP: begin
          mask_r <= mask_nxt_s;
          hitm_r <= hitm_nxt_s;
          hit_r  <= hit_nxt_s;
          if (all_acked_s || snp_last_s) begin
            snp_valid   <= 1'b0;
            timeout_err <= ~all_acked_s;
            cnt_r       <= '0;
            if (hitm_nxt_s) begin
              state_r <= WB_WAIT;
            end else if (op_r == OP_INV) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_snoop <= combine(hitm_nxt_s, hit_nxt_s);
            end else begin
              state_r <= MEM;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WB_WAIT: begin
          if (wb_valid || snp_last_s) begin
            timeout_err <= ~wb_valid;
            cnt_r       <= '0;
            if (op_r == OP_INV) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_snoop <= combine(hitm_r, hit_r);
            end else begin
              state_r <= MEM;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        MEM: begin
          if (cnt_r == MEM_LAST) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_snoop <= combine(hitm_r, hit_r);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          snp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_bus_responder.sv
`timescale 1ns/1ps
// Directed self-checking bench for llc_bus_responder. Expected responses and
// timeout pulses are queued with their cycle numbers when a request is driven;
// a negedge monitor pops and compares them when the DUT produces them.
module tb_llc_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        snp_valid;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic [2:0]  snp_ack;
  logic [5:0]  snp_result;
  logic        wb_valid;
  logic        rsp_valid;
  logic [1:0]  rsp_snoop;
  logic        timeout_err;

  llc_bus_responder #(
    .ADDR_BITS(32), .PEERS(3), .SNOOP_TIMEOUT(15), .MEM_LATENCY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr),
    .snp_ack(snp_ack), .snp_result(snp_result), .wb_valid(wb_valid),
    .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop), .timeout_err(timeout_err)
  );

  typedef struct {
    int         cyc;
    logic [1:0] snoop;
  } rsp_exp_t;

  rsp_exp_t rsp_q[$];
  int       tmo_q[$];
  rsp_exp_t mon_e;
  int       mon_t;
  int       cyc;
  int       checks;
  int       errors;
  int       t0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, output int ts);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    ts        = cyc;
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic push_rsp(input int c, input logic [1:0] s);
    rsp_exp_t e;
    e.cyc   = c;
    e.snoop = s;
    rsp_q.push_back(e);
  endtask

  // Scoreboard monitor: compares every response / timeout pulse against the
  // queue and flags expected events whose cycle passed without them.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
      end else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_cycle", cyc, mon_e.cyc);
        chk("rsp_snoop", {62'd0, rsp_snoop}, {62'd0, mon_e.snoop});
      end
    end else if (rsp_q.size() != 0 && cyc > rsp_q[0].cyc) begin
      mon_e = rsp_q.pop_front();
      chk("rsp_missing", {63'd0, rsp_valid}, 64'd1);
    end
    if (timeout_err === 1'b1) begin
      if (tmo_q.size() == 0) begin
        chk("tmo_unexpected", {63'd0, timeout_err}, 64'd0);
      end else begin
        mon_t = tmo_q.pop_front();
        chk("tmo_cycle", cyc, mon_t);
      end
    end else if (tmo_q.size() != 0 && cyc > tmo_q[0]) begin
      mon_t = tmo_q.pop_front();
      chk("tmo_missing", {63'd0, timeout_err}, 64'd1);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_snp_valid"}, {63'd0, snp_valid}, 64'd0);
    chk({tag, "_snp_op"}, {61'd0, snp_op}, 64'd0);
    chk({tag, "_snp_addr"}, {32'd0, snp_addr}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_snoop"}, {62'd0, rsp_snoop}, 64'd2);
    chk({tag, "_timeout_err"}, {63'd0, timeout_err}, 64'd0);
  endtask

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_addr   = 32'd0;
    snp_ack    = 3'b000;
    snp_result = 6'b111111;
    wb_valid   = 1'b0;

    // Reset state
    repeat (2) next_cycle();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // READ, all peers ack in cycle 1 (peer 1 with code 11 = NOHIT)
    issue(3'd1, 32'h1000_0004, t0);
    push_rsp(t0 + 6, 2'b10);
    snp_ack    = 3'b111;
    snp_result = {2'b10, 2'b11, 2'b10};
    chk("read_snp_valid", {63'd0, snp_valid}, 64'd1);
    chk("read_snp_op", {61'd0, snp_op}, 64'd1);
    chk("read_snp_addr", {32'd0, snp_addr}, 64'h1000_0004);
    chk("read_req_ready_busy", {63'd0, req_ready}, 64'd0);
    next_cycle();
    snp_ack    = 3'b000;
    snp_result = 6'b111111;
    chk("read_snp_done", {63'd0, snp_valid}, 64'd0);
    run_to(t0 + 7);
    chk("read_req_ready_back", {63'd0, req_ready}, 64'd1);

    // RWIM: acks spread over cycles 1-3, HITM from peer 2, wb_valid k=2
    issue(3'd4, 32'h2000_0040, t0);
    push_rsp(t0 + 11, 2'b01);
    snp_ack = 3'b001; snp_result = {2'b11, 2'b11, 2'b00};
    next_cycle();
    snp_ack = 3'b010; snp_result = {2'b11, 2'b10, 2'b11}; wb_valid = 1'b1;
    next_cycle();
    snp_ack = 3'b100; snp_result = {2'b01, 2'b11, 2'b11}; wb_valid = 1'b0;
    next_cycle();
    snp_ack = 3'b000; snp_result = 6'b111111;
    chk("rwim_wbwait_snp_valid", {63'd0, snp_valid}, 64'd1 - 64'd1);
    next_cycle();
    next_cycle();
    wb_valid = 1'b1;
    next_cycle();
    wb_valid = 1'b0;
    run_to(t0 + 12);

    // INVALIDATE: all ack in cycle 1, peer 0 repeats with HITM afterwards
    issue(3'd3, 32'h0000_0ff0, t0);
    push_rsp(t0 + 2, 2'b00);
    snp_ack = 3'b111; snp_result = {2'b10, 2'b10, 2'b00};
    next_cycle();
    snp_ack = 3'b001; snp_result = {2'b11, 2'b11, 2'b01};
    next_cycle();
    snp_ack = 3'b000; snp_result = 6'b111111;
    chk("inv_req_ready_back", {63'd0, req_ready}, 64'd1);

    // READ snoop timeout: peer 2 never acks, peer 0 repeats with HITM code
    issue(3'd1, 32'h3000_0100, t0);
    push_rsp(t0 + 20, 2'b00);
    tmo_q.push_back(t0 + 16);
    snp_ack = 3'b011; snp_result = {2'b11, 2'b11, 2'b00};
    next_cycle();
    snp_ack = 3'b001; snp_result = {2'b11, 2'b11, 2'b01};
    next_cycle();
    snp_ack = 3'b000; snp_result = 6'b111111;
    run_to(t0 + 15);
    chk("tmo_last_snoop", {63'd0, snp_valid}, 64'd1);
    next_cycle();
    chk("tmo_snoop_left", {63'd0, snp_valid}, 64'd0);
    run_to(t0 + 21);

    // Reset asserted during MEM of a READ
    issue(3'd1, 32'h4000_0000, t0);
    snp_ack = 3'b111; snp_result = {2'b10, 2'b10, 2'b10};
    next_cycle();
    snp_ack = 3'b000; snp_result = 6'b111111;
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (8) next_cycle();
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);

    // INVALIDATE with HITM and no writeback: WB_WAIT times out
    issue(3'd3, 32'h5000_0008, t0);
    push_rsp(t0 + 17, 2'b01);
    tmo_q.push_back(t0 + 17);
    snp_ack = 3'b111; snp_result = {2'b10, 2'b01, 2'b10};
    next_cycle();
    snp_ack = 3'b000; snp_result = 6'b111111;
    run_to(t0 + 18);

    // WRITE with req_valid held high (op 6): next accept the cycle after RESP
    t0        = cyc;
    req_valid = 1'b1;
    req_op    = 3'd2;
    req_addr  = 32'h6000_0000;
    push_rsp(t0 + 5, 2'b10);
    push_rsp(t0 + 7, 2'b10);
    next_cycle();
    req_op     = 3'd6;
    snp_ack    = 3'b111;
    snp_result = 6'b000000;
    for (int n = 1; n <= 4; n++) begin
      chk("write_snp_valid", {63'd0, snp_valid}, 64'd0);
      chk("write_req_ready", {63'd0, req_ready}, 64'd0);
      next_cycle();
    end
    snp_ack    = 3'b000;
    snp_result = 6'b111111;
    next_cycle();
    chk("write_req_ready_back", {63'd0, req_ready}, 64'd1);
    next_cycle();
    req_valid = 1'b0;
    run_to(t0 + 9);

    // Drain: any still-pending expectation is reported as missing
    for (int n = 0; n < 30 && (rsp_q.size() != 0 || tmo_q.size() != 0); n++) next_cycle();
    chk("rsp_queue_empty", rsp_q.size(), 64'd0);
    chk("tmo_queue_empty", tmo_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
